// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - block-transfer SDRAM model answering cache line fills and write-backs
module sdram_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int OFFSET_BITS = 5,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Address_sdram,
    input  logic                  wr_rd_sdram,
    input  logic                  mstrb_sdram,
    input  logic [DATA_WIDTH-1:0] DIn_sdram,
    output logic [DATA_WIDTH-1:0] DOut_sdram,
    output logic                  dvalid_sdram,
    output logic                  rdy_sdram,
    output logic                  done_sdram
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Low address bits that select a word inside one block
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    // Index of the final word of a block
    localparam logic [OFFSET_BITS-1:0] LAST_IDX = '1;

    // Latency counter preload; reaching zero means the next edge starts the transfer
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base;
    logic                    dir;
    logic [3:0]              cnt;
    logic [OFFSET_BITS-1:0]  idx;
    logic [OFFSET_BITS-1:0]  next_idx;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-1:0]   next_addr;

    // Backing store: powers up zeroed and deliberately survives rst
    logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};

    // Word index wraps inside the block, so OR-ing onto the aligned base never touches tag bits
    assign next_idx  = idx + OFFSET_BITS'(1);
    assign cur_addr  = base | ADDR_WIDTH'(idx);
    assign next_addr = base | ADDR_WIDTH'(next_idx);

    // Write-back: commit the cache word at the edge that closes its dvalid cycle
    always_ff @(posedge clk) begin
        if (!rst && dvalid_sdram && dir) begin
            mem[cur_addr] <= DIn_sdram;
        end
    end

    // Transfer sequencer: accept in IDLE, count latency, stream one block, pulse done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            base         <= '0;
            dir          <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            DOut_sdram   <= '0;
            dvalid_sdram <= 1'b0;
            rdy_sdram    <= 1'b1;
            done_sdram   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mstrb_sdram) begin
                        base      <= Address_sdram & ~OFFSET_MASK;
                        dir       <= wr_rd_sdram;
                        cnt       <= LAT_LOAD;
                        rdy_sdram <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        idx          <= '0;
                        dvalid_sdram <= 1'b1;
                        state        <= XFER;
                        if (!dir) begin
                            DOut_sdram <= mem[base];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                XFER: begin
                    if (idx == LAST_IDX) begin
                        dvalid_sdram <= 1'b0;
                        done_sdram   <= 1'b1;
                        state        <= DONE;
                    end else begin
                        idx <= next_idx;
                        if (!dir) begin
                            DOut_sdram <= mem[next_addr];
                        end
                    end
                end
                DONE: begin
                    done_sdram <= 1'b0;
                    rdy_sdram  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - self-checking bench for sdram_responder
module tb_sdram_responder;

    localparam int L  = 4;
    localparam int NW = 32;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [15:0] addr   = '0;
    logic        wr     = 1'b0;
    logic        mstrb  = 1'b0;
    logic [7:0]  din    = 8'hEE;
    logic [7:0]  dout;
    logic        dvalid, rdy, done;

    logic [15:0] addr1  = '0;
    logic        wr1    = 1'b0;
    logic        mstrb1 = 1'b0;
    logic [7:0]  din1   = '0;
    logic [7:0]  dout1;
    logic        dvalid1, rdy1, done1;

    always #5 clk = ~clk;

    sdram_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .OFFSET_BITS(5), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .Address_sdram(addr), .wr_rd_sdram(wr), .mstrb_sdram(mstrb),
        .DIn_sdram(din), .DOut_sdram(dout), .dvalid_sdram(dvalid), .rdy_sdram(rdy), .done_sdram(done)
    );

    sdram_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .OFFSET_BITS(5), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .Address_sdram(addr1), .wr_rd_sdram(wr1), .mstrb_sdram(mstrb1),
        .DIn_sdram(din1), .DOut_sdram(dout1), .dvalid_sdram(dvalid1), .rdy_sdram(rdy1), .done_sdram(done1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request occupies L+34 edges counted from acceptance
    logic [7:0]  mem_model [65536];
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    logic [15:0] m_base = '0;
    bit          m_dir  = 1'b0;
    bit          exp_rdy = 1'b1, exp_dvalid = 1'b0, exp_done = 1'b0;
    logic [7:0]  exp_dout = '0;
    int          exp_word = 0;

    initial for (int i = 0; i < 65536; i++) mem_model[i] = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_age    = 0;
            m_base   = '0;
            m_dir    = 1'b0;
            exp_dout = '0;
        end else begin
            if (exp_dvalid && m_dir) mem_model[m_base + 16'(exp_word)] = din;
            if (!m_busy) begin
                if (mstrb) begin
                    m_busy = 1'b1;
                    m_age  = 0;
                    m_base = 16'((int'(addr) / NW) * NW);
                    m_dir  = wr;
                end
            end else begin
                m_age++;
                if (m_age == L + NW + 1) m_busy = 1'b0;
            end
            if (m_busy && !m_dir && m_age >= L && m_age < L + NW)
                exp_dout = mem_model[m_base + 16'(m_age - L)];
        end
        exp_rdy    = !m_busy;
        exp_dvalid = m_busy && m_age >= L && m_age < L + NW;
        exp_done   = m_busy && m_age == L + NW;
        exp_word   = m_age - L;
    end

    // Cycle-by-cycle comparison of the LATENCY=4 instance against the model
    always @(negedge clk) begin
        check("cyc_rdy",    32'(rdy),    32'(exp_rdy));
        check("cyc_dvalid", 32'(dvalid), 32'(exp_dvalid));
        check("cyc_done",   32'(done),   32'(exp_done));
        check("cyc_dout",   32'(dout),   32'(exp_dout));
    end

    // Per-transaction observations of the DUT
    logic [7:0] din_base = 8'h10;
    bit         prev_rdy = 1'b1;
    int         n_acc, acc_cyc, dv_cyc, n_dv, n_done, done_cyc, rdy_cyc;
    logic [7:0] dq [$];
    int         acc_q [$];

    task automatic clear_stats();
        n_acc = 0; acc_cyc = 0; dv_cyc = 0; n_dv = 0; n_done = 0; done_cyc = 0; rdy_cyc = 0;
        dq.delete();
        acc_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        din = exp_dvalid ? din_base + 8'(exp_word) : 8'hEE;
        if (prev_rdy && !rdy) begin n_acc++; acc_cyc = cyc; acc_q.push_back(cyc); end
        if (dvalid) begin
            if (n_dv == 0) dv_cyc = cyc;
            n_dv++;
            dq.push_back(dout);
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (rdy && !prev_rdy) rdy_cyc = cyc;
        prev_rdy = rdy;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic request(input string name, input logic [15:0] a, input logic w);
        addr  = a;
        wr    = w;
        mstrb = 1'b1;
        step();
        mstrb = 1'b0;
        check(name, 32'(rdy), 32'd0);
    endtask

    int bad;
    int a1, first1, busy1, ndv1, bad1, done1_n;

    initial begin
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy",     32'(rdy),     32'd1);
        check("rst_dvalid",  32'(dvalid),  32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_dout",    32'(dout),    32'd0);
        check("rst_rdy_l1",  32'(rdy1),    32'd1);
        check("rst_dout_l1", 32'(dout1),   32'd0);
        rst = 1'b0;

        // Write-back of block A0A0..A0BF with data 10..2F
        clear_stats();
        din_base = 8'h10;
        request("wb_rdy_fall", 16'hA0B0, 1'b1);
        run(40);
        check("wb_first_dvalid", 32'(dv_cyc - acc_cyc), 32'd4);
        check("wb_dvalid_count", 32'(n_dv),             32'd32);
        check("wb_done_count",   32'(n_done),           32'd1);
        check("wb_rdy_return",   32'(rdy_cyc - done_cyc), 32'd1);
        bad = 0;
        for (int i = 0; i < NW; i++) if (mem_model[16'hA0A0 + 16'(i)] !== 8'h10 + 8'(i)) bad++;
        check("model_wb_mem", 32'(bad), 32'd0);
        check("model_no_spill", 32'(mem_model[16'hA0C0]) | 32'(mem_model[16'hA09F]), 32'd0);

        // Line fill from inside the same block
        clear_stats();
        request("lf_rdy_fall", 16'hA0BF, 1'b0);
        run(40);
        check("lf_count", 32'(dq.size()), 32'd32);
        bad = 0;
        for (int i = 0; i < dq.size(); i++) if (dq[i] !== 8'h10 + 8'(i)) bad++;
        check("lf_data", 32'(bad), 32'd0);
        check("lf_dout_hold", 32'(dout), 32'h2F);

        // Reset after 10 written words of a write-back to 4000
        clear_stats();
        din_base = 8'h10;
        request("rst_wb_rdy_fall", 16'h4000, 1'b1);
        for (int i = 0; i < 60 && n_dv < 11; i++) step();
        check("rst_reached_word10", 32'(n_dv), 32'd11);
        #2;
        rst = 1'b1;
        #1;
        check("async_rdy",    32'(rdy),    32'd1);
        check("async_dvalid", 32'(dvalid), 32'd0);
        check("async_done",   32'(done),   32'd0);
        check("async_dout",   32'(dout),   32'd0);
        step();
        step();
        rst = 1'b0;
        run(3);
        check("rst_no_done", 32'(n_done), 32'd0);
        clear_stats();
        request("rst_lf_rdy_fall", 16'h4000, 1'b0);
        run(40);
        check("rst_lf_count", 32'(dq.size()), 32'd32);
        bad = 0;
        for (int i = 0; i < dq.size(); i++)
            if (dq[i] !== ((i < 10) ? 8'h10 + 8'(i) : 8'h00)) bad++;
        check("rst_lf_data", 32'(bad), 32'd0);

        // Strobes to 1234 during WAIT and during DONE are ignored
        clear_stats();
        request("busy_rdy_fall", 16'hA0A0, 1'b0);
        step();
        addr = 16'h1234; wr = 1'b1; mstrb = 1'b1;
        step();
        mstrb = 1'b0;
        for (int i = 0; i < 60 && !exp_done; i++) step();
        check("busy_in_done", 32'(done), 32'd1);
        addr = 16'h1234; wr = 1'b1; mstrb = 1'b1;
        step();
        mstrb = 1'b0;
        run(5);
        check("busy_acc_count",  32'(n_acc),  32'd1);
        check("busy_done_count", 32'(n_done), 32'd1);
        clear_stats();
        request("busy_lf_rdy_fall", 16'h1234, 1'b0);
        run(40);
        check("busy_lf_count", 32'(dq.size()), 32'd32);
        bad = 0;
        for (int i = 0; i < dq.size(); i++) if (dq[i] !== 8'h00) bad++;
        check("busy_lf_data", 32'(bad), 32'd0);

        // LATENCY=1 line fill from 0000
        first1 = -1; busy1 = 0; ndv1 = 0; bad1 = 0; done1_n = 0;
        addr1 = 16'h0000; wr1 = 1'b0; mstrb1 = 1'b1;
        @(posedge clk);
        #1;
        mstrb1 = 1'b0;
        a1 = cyc;
        check("l1_rdy_fall", 32'(rdy1), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (!rdy1) busy1++;
            if (done1) done1_n++;
            if (dvalid1) begin
                if (first1 < 0) first1 = cyc - a1;
                ndv1++;
                if (dout1 !== 8'h00) bad1++;
            end
            @(posedge clk);
            #1;
        end
        check("l1_first_dvalid", 32'(first1),  32'd1);
        check("l1_busy_edges",   32'(busy1),   32'd34);
        check("l1_dvalid_count", 32'(ndv1),    32'd32);
        check("l1_data",         32'(bad1),    32'd0);
        check("l1_done_count",   32'(done1_n), 32'd1);

        // Strobe held high across two blocks
        clear_stats();
        addr = 16'h2000; wr = 1'b0; mstrb = 1'b1;
        for (int i = 0; i < 120 && n_acc < 2; i++) step();
        mstrb = 1'b0;
        run(45);
        check("held_acc_count", 32'(acc_q.size()), 32'd2);
        check("held_spacing", (acc_q.size() == 2) ? 32'(acc_q[1] - acc_q[0]) : 32'hFFFF_FFFF, 32'(L + NW + 2));
        check("held_done_count", 32'(n_done), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning the byte address width on the memory side.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the word width.
REQ-003 SHALL have parameter OFFSET_BITS, default 5, meaning log2 of the block length in words (32 words).
REQ-004 SHALL have parameter LATENCY, default 4, meaning access latency in clocks; legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port Address_sdram, input, ADDR_WIDTH bits: block address from the cache controller.
REQ-008 SHALL have port wr_rd_sdram, input, 1 bit: direction; 1 = write-back (cache to memory), 0 = line fill (memory to cache).
REQ-009 SHALL have port mstrb_sdram, input, 1 bit: memory strobe requesting one block transfer.
REQ-010 SHALL have port DIn_sdram, input, DATA_WIDTH bits: write-back data from the cache.
REQ-011 SHALL have port DOut_sdram, output, DATA_WIDTH bits: line-fill data to the cache, registered.
REQ-012 SHALL have port dvalid_sdram, output, 1 bit: word strobe, high for exactly one cycle per transferred word.
REQ-013 SHALL have port rdy_sdram, output, 1 bit: high only in IDLE, when a request can be accepted.
REQ-014 SHALL have port done_sdram, output, 1 bit: one-cycle pulse at block completion.

Function
REQ-015 SHALL contain a storage array of 2^ADDR_WIDTH words; it is zero at elaboration and SHALL NOT be cleared by rst.
REQ-016 SHALL implement the FSM states IDLE, WAIT, XFER and DONE; all outputs SHALL be registered.
REQ-017 In IDLE, on an edge with mstrb_sdram=1, the block SHALL:
- latch base = Address_sdram with its low OFFSET_BITS forced to 0;
- latch wr_rd_sdram;
- load the latency counter with LATENCY-1 and enter WAIT.
REQ-018 In WAIT, the block SHALL decrement the counter each edge; on the edge where it reads 0, it SHALL enter XFER with word index 0 and dvalid_sdram=1.
REQ-019 The first dvalid_sdram cycle SHALL begin exactly LATENCY edges after the accepting edge.
REQ-020 On a line fill in XFER, DOut_sdram SHALL equal mem[base+idx] during the cycle in which dvalid_sdram is high for word idx.
REQ-021 On a write-back in XFER, the block SHALL write DIn_sdram to mem[base+idx] at the edge that ends the dvalid_sdram cycle for word idx.
REQ-022 The word index SHALL increment each XFER edge; after word 2^OFFSET_BITS-1, the block SHALL enter DONE with dvalid_sdram=0 and done_sdram=1.
REQ-023 DONE SHALL last one cycle, then return to IDLE with rdy_sdram=1.
REQ-024 The word index SHALL NOT carry into the tag bits; base+idx SHALL stay inside the latched block.
REQ-025 mstrb_sdram, Address_sdram and wr_rd_sdram SHALL be ignored outside IDLE, including in DONE; a strobe held high SHALL be re-accepted on the first IDLE edge.
REQ-026 Back-to-back requests SHALL therefore have a minimum spacing of LATENCY + 2^OFFSET_BITS + 2 edges.
REQ-027 DOut_sdram SHALL hold its last value when dvalid_sdram=0.

Reset
REQ-028 While rst=1, outputs SHALL be: state IDLE, rdy_sdram=1, dvalid_sdram=0, done_sdram=0, DOut_sdram=0, counters 0, latched base and direction 0.
REQ-029 A reset asserted mid-transfer SHALL abort the transfer immediately.
REQ-030 After such an abort, words already written SHALL remain in memory, no further words SHALL be written, and no done_sdram pulse SHALL occur.
REQ-031 The first request SHALL be accepted on the first rising edge with rst=0 and mstrb_sdram=1.

Verification
REQ-032 Write-back of a block:
- stimulus: Address_sdram=16'hA0B0, wr_rd=1, one-cycle strobe; DIn = 8'h10+idx on each dvalid;
- response: rdy falls the next cycle; first dvalid 4 edges after acceptance; 32 dvalid cycles; done pulses once; rdy returns one cycle later;
- memory: mem[16'hA0A0..16'hA0BF] = 8'h10..8'h2F.
REQ-033 Line fill after REQ-032:
- stimulus: Address_sdram=16'hA0BF, wr_rd=0;
- response: base is 16'hA0A0; DOut on successive dvalid cycles is 8'h10..8'h2F in order.
REQ-034 Strobe while busy:
- stimulus: pulse mstrb_sdram with Address_sdram=16'h1234 during WAIT and again during DONE;
- response: neither is accepted; no state change; mem[16'h1220..16'h123F] unchanged.
REQ-035 Reset mid-transfer:
- stimulus: assert rst after 10 dvalid cycles of a write-back to 16'h4000;
- response: outputs reach reset values asynchronously; mem[16'h4000..16'h4009] written and mem[16'h400A..16'h401F] still 0; no done pulse.
REQ-036 Parameter corner, LATENCY=1:
- stimulus: a line fill from 16'h0000;
- response: dvalid rises on the edge immediately after acceptance; total busy time is 34 edges.
REQ-037 Held strobe:
- stimulus: hold mstrb_sdram high across two blocks;
- response: the second acceptance happens on the first IDLE edge; exactly 2 done pulses.
